// File: rtl/nn_accelerator.sv
// nn_accelerator: fully-connected layer engine, output_vector = W * x.
// Free-running frame of N+2 phases: load, N MAC steps, commit.
module nn_accelerator #(
  parameter int DATA_W = 32,
  parameter int N      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] input_vector  [0:N-1],
  input  logic [DATA_W-1:0] weight_matrix [0:N-1][0:N-1],
  output logic [DATA_W-1:0] output_vector [0:N-1]
);

  localparam int PW = $clog2(N + 2);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] COMMIT = PW'(N + 1);

  logic [PW-1:0]     phase;
  logic [KW-1:0]     k;
  logic              is_load;
  logic              is_mac;
  logic              is_commit;
  logic [DATA_W-1:0] x_s  [0:N-1];
  logic [DATA_W-1:0] w_s  [0:N-1][0:N-1];
  logic [DATA_W-1:0] acc  [0:N-1];
  logic [DATA_W-1:0] prod [0:N-1];

  always_comb begin
    is_load   = (phase == '0);
    is_commit = (phase >= COMMIT);
    is_mac    = !is_load && !is_commit;
    k         = KW'(phase - PW'(1));
  end

  // Low DATA_W bits of a signed product match the unsigned product.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod[i] = w_s[i][k] * x_s[k];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (is_commit) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        x_s[i] <= '0;
        for (int j = 0; j < N; j++) begin
          w_s[i][j] <= '0;
        end
      end
    end else if (is_load) begin
      for (int i = 0; i < N; i++) begin
        x_s[i] <= input_vector[i];
        for (int j = 0; j < N; j++) begin
          w_s[i][j] <= weight_matrix[i][j];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
      end
    end else if (is_load) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
      end
    end else if (is_mac) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= acc[i] + prod[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        output_vector[i] <= '0;
      end
    end else if (is_commit) begin
      for (int i = 0; i < N; i++) begin
        output_vector[i] <= acc[i];
      end
    end
  end

endmodule

// File: tb/tb_nn_accelerator.sv
// tb_nn_accelerator: directed frames for nn_accelerator.
// Expected vectors are queued at load and popped at commit.
module tb_nn_accelerator;

  typedef logic [3:0][31:0]      vec_t;
  typedef logic [3:0][3:0][31:0] mat_t;

  logic        clock;
  logic        reset;
  logic [31:0] xin  [0:3];
  logic [31:0] win  [0:3][0:3];
  logic [31:0] yout [0:3];

  int   checks;
  int   failures;
  vec_t sb [$];
  vec_t held;
  vec_t exp_v;
  vec_t x;
  mat_t w;

  nn_accelerator #(.DATA_W(32), .N(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .input_vector  (xin),
    .weight_matrix (win),
    .output_vector (yout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t model(input vec_t xv, input mat_t wm);
    vec_t r;
    logic [31:0] s;
    for (int i = 0; i < 4; i++) begin
      s = '0;
      for (int j = 0; j < 4; j++) begin
        s = s + 32'(wm[i][j] * xv[j]);
      end
      r[i] = s;
    end
    return r;
  endfunction

  task automatic drive(input vec_t xv, input mat_t wm);
    for (int i = 0; i < 4; i++) begin
      xin[i] = xv[i];
      for (int j = 0; j < 4; j++) begin
        win[i][j] = wm[i][j];
      end
    end
  endtask

  task automatic check_vec(input string tag, input vec_t e);
    for (int i = 0; i < 4; i++) begin
      checks++;
      assert (yout[i] === e[i]) else begin
        failures++;
        $error("FAIL %s[%0d] observed=%h expected=%h",
               tag, i, yout[i], e[i]);
      end
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load(input vec_t xv, input mat_t wm);
    drive(xv, wm);
    sb.push_back(model(xv, wm));
  endtask

  // Runs 5 edges checking the held value, then the commit edge.
  task automatic finish_frame(input string tag);
    edges(5);
    check_vec({tag, "_hold"}, held);
    edges(1);
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      check_vec(tag, exp_v);
      held = exp_v;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    held     = '0;
    reset    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x[i] = $urandom;
      for (int j = 0; j < 4; j++) w[i][j] = $urandom;
    end
    drive(x, w);
    #1;
    check_vec("reset_init", '0);
    edges(3);
    check_vec("reset_edges", '0);
    for (int i = 0; i < 4; i++) x[i] = $urandom;
    drive(x, w);
    edges(4);
    check_vec("reset_hold", '0);

    for (int i = 0; i < 4; i++) begin
      x[i] = 32'(i + 2);
      for (int j = 0; j < 4; j++) w[i][j] = 32'd1;
    end
    load(x, w);
    reset = 1'b1;
    finish_frame("basic");

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) w[i][j] = (i == j) ? 32'd1 : 32'd0;
    end
    x[0] = 32'd7;
    x[1] = -32'sd3;
    x[2] = 32'd0;
    x[3] = 32'd100;
    load(x, w);
    finish_frame("identity");

    for (int i = 0; i < 4; i++) begin
      x[i] = (i == 0) ? 32'hFFFF_FFFF : 32'd0;
      w[i][0] = 32'd2;
      for (int j = 1; j < 4; j++) w[i][j] = $urandom;
    end
    load(x, w);
    finish_frame("neg");

    for (int i = 0; i < 4; i++) begin
      x[i] = 32'h4000_0000;
      for (int j = 0; j < 4; j++) w[i][j] = 32'd1;
    end
    load(x, w);
    finish_frame("wrap");

    for (int i = 0; i < 4; i++) begin
      x[i] = 32'(3 * i + 1);
      for (int j = 0; j < 4; j++) w[i][j] = 32'(i + j);
    end
    load(x, w);
    edges(2);
    for (int i = 0; i < 4; i++) x[i] = 32'(50 - 7 * i);
    drive(x, w);
    edges(3);
    check_vec("midframe_hold", held);
    edges(1);
    exp_v = sb.pop_front();
    check_vec("midframe_snap", exp_v);
    held = exp_v;
    load(x, w);
    finish_frame("midframe_next");

    for (int i = 0; i < 4; i++) begin
      x[i] = 32'(i + 9);
      for (int j = 0; j < 4; j++) w[i][j] = 32'(j + 1);
    end
    load(x, w);
    edges(3);
    reset = 1'b0;
    #1;
    check_vec("reset_mid", '0);
    void'(sb.pop_front());
    held = '0;
    edges(2);
    check_vec("reset_mid_hold", '0);
    load(x, w);
    reset = 1'b1;
    finish_frame("after_reset");

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
